multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle MIPS control FSM that sequences the shared datapath: one ALU, one unified memory, register file, IR and PC are reused across the cycles of each instruction. Sits beside the datapath, takes the IR opcode and a memory-ready handshake, and drives every mux select and write enable per state. It replaces single-cycle decode for the multi-cycle core and adds a retired-instruction counter.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  out  1 each  datapath enables/selects
- MemToReg, RegDst, RegWrite, ALUSrcA, ExtOp  out  1 each  (ExtOp=1 zero-extend imm)
- ALUSrcB  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUOp  out  3  000 add, 001 sub, 010 funct, 011 slt, 100 and, 101 or
- state  out  4  current state encoding (debug)
- instret  out  32  retired-instruction count
- illegal  out  1  trap flag (only with macro)

## Operation
- Outputs are a decode of the state register (Moore); IRWrite and PCWrite in FETCH additionally gated by mem_ready.
- Default for every output not listed in a state: 0.
- FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00; IRWrite=PCWrite=mem_ready. Stay while !mem_ready, else DECODE.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target to ALUOut). Latch opcode into op_q. Dispatch: 100011/101011 -> MEM_ADDR; 000000 -> EXECUTE; 001000/001100/001101/001010 -> IMM_EXEC; 000100 -> BRANCH; 000010 -> JUMP; other -> see Configuration.
- MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=000. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ(3): MemRead=1, IorD=1; hold until mem_ready -> MEM_WB.
- MEM_WB(4): RegWrite=1, MemToReg=1, RegDst=0 -> FETCH.
- MEM_WRITE(5): MemWrite=1, IorD=1; hold until mem_ready -> FETCH.
- EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=010 -> R_WB(7): RegWrite=1, RegDst=1 -> FETCH.
- IMM_EXEC(10): ALUSrcA=1, ALUSrcB=10; ALUOp from op_q: addi 000, andi 100, ori 101, slti 011; ExtOp=1 for andi/ori -> IMM_WB(11): RegWrite=1, RegDst=0 (ExtOp held) -> FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP(9): PCWrite=1, PCSource=10 -> FETCH.
- instret increments by 1 on every transition into FETCH from a non-FETCH state (not from TRAP); wraps 0xFFFFFFFF -> 0.
- Unused encodings 12–15 other than TRAP: next state FETCH, outputs default.

## Timing
- Reset (async, immediate): state=FETCH, op_q=0, instret=0, illegal=0; outputs equal FETCH decode (MemRead=1, ALUSrcB=01, IRWrite=PCWrite=mem_ready).
- Latency with mem_ready=1 always: lw 5, sw 4, R-type 4, immediate 4, beq 3, j 3 cycles.
- Each !mem_ready cycle in FETCH/MEM_READ/MEM_WRITE adds one cycle; memory-state outputs held stable during stall.
- mem_ready ignored in all other states.
- Reset asserted mid-instruction aborts it; no partial instret increment.

## Configuration
- MULTICYCLE_ILLEGAL_TRAP_EN defined: undefined opcode in DECODE -> TRAP(12); illegal=1, all enables 0, state held until reset; instret frozen.
- Not defined: undefined opcode -> FETCH (NOP, counted in instret); illegal tied 0; TRAP unreachable.

## Structure
- Shared package mc_pkg: state encodings, ALUOp codes, ALUSrcB/PCSource codes, opcode constants (OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J).
- One sub-module: mc_output_decode (combinational state/op_q/mem_ready -> control outputs); FSM, op_q and instret in the top.

## Test plan
- Reset then lw (100011), mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=MemToReg=1 only in state 4; instret=1.
- sw with mem_ready low 3 cycles in MEM_WRITE -> MemWrite=1 held 4 cycles, total 7 cycles, RegWrite never 1.
- andi (001100) -> IMM_EXEC ALUOp=100, ExtOp=1; slti -> ALUOp=011, ExtOp=0; both 4 cycles.
- beq then j -> state 8 with PCWriteCond=1, PCSource=01; state 9 with PCWrite=1, PCSource=10; instret +2.
- Opcode 111111 -> with macro state 12, illegal=1 held, instret unchanged; without macro back to FETCH, instret+1.
- rst_n low during MEM_READ -> state=0, instret=0 same cycle; instret 0xFFFFFFFF + one R-type -> 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, ALU/mux codes, opcodes.
// The TRAP state is only reachable when MULTICYCLE_ILLEGAL_TRAP_EN is defined.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       ext_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // Logical immediates (andi/ori) take a zero-extended immediate; the rest sign-extend.
  function automatic logic imm_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    logic [2:0] code;
    case (op)
      OP_ANDI: code = ALU_AND;
      OP_ORI:  code = ALU_OR;
      OP_SLTI: code = ALU_SLT;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle FSM (master) and the shared datapath (slave).
interface multicycle_control_if;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        MemToReg;
  logic        RegDst;
  logic        RegWrite;
  logic        ALUSrcA;
  logic        ExtOp;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSource;
  logic [2:0]  ALUOp;
  logic [3:0]  state;
  logic [31:0] instret;
  logic        illegal;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ExtOp, ALUSrcB, PCSource,
           ALUOp, state, instret, illegal
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ExtOp, ALUSrcB, PCSource,
           ALUOp, state, instret, illegal
  );
endinterface

// File: rtl/mc_output_decode.sv
// Moore decode of FSM state (plus latched opcode) into datapath controls.
// The illegal flag is only driven when MULTICYCLE_ILLEGAL_TRAP_EN is defined.
module mc_output_decode
  import mc_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        // IR and PC only update once the instruction word has actually arrived.
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_IMM_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = imm_alu_op(op_i);
        ctrl_o.ext_op    = imm_zero_ext(op_i);
      end
      S_IMM_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.ext_op    = imm_zero_ext(op_i);
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP: begin
        ctrl_o.illegal = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with retired-instruction counter.
// MULTICYCLE_ILLEGAL_TRAP_EN: undefined opcodes park the FSM in TRAP instead of acting as NOPs.
module multicycle_control
  import mc_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  multicycle_control_if.master       bus
);

  state_e      state_q, state_d;
  logic [5:0]  op_q;
  logic [31:0] instret_q;
  logic        retire;
  ctrl_t       ctrl;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
          OP_RTYPE:                           state_d = S_EXECUTE;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_IMM_EXEC;
          OP_BEQ:                             state_d = S_BRANCH;
          OP_J:                               state_d = S_JUMP;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:                            state_d = S_TRAP;
`else
          default:                            state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR:  state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_IMM_EXEC:  state_d = S_IMM_WB;
      S_IMM_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP:      state_d = S_TRAP;
`endif
      default:     state_d = S_FETCH;
    endcase
  end

  // An instruction retires when control returns to FETCH; a FETCH stall is not a retirement.
  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= bus.opcode;
      end
      if (retire) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  mc_output_decode u_decode (
    .state_i     (state_q),
    .op_i        (op_q),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemToReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ExtOp       = ctrl.ext_op;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.illegal     = ctrl.illegal;
  assign bus.state       = state_q;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through the FSM.
// Expectations for undefined opcodes follow MULTICYCLE_ILLEGAL_TRAP_EN.
module tb_multicycle_control;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic ready);
    bus.opcode    = op;
    bus.mem_ready = ready;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.opcode    = 6'b0;
    bus.mem_ready = 1'b1;

    // Asynchronous reset, FETCH decode with and without mem_ready
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_state", 32'(bus.state), 32'd0);
    checkOutput("rst_instret", bus.instret, 32'd0);
    checkOutput("rst_illegal", 32'(bus.illegal), 32'd0);
    checkOutput("rst_memread", 32'(bus.MemRead), 32'd1);
    checkOutput("rst_alusrcb", 32'(bus.ALUSrcB), 32'd1);
    checkOutput("rst_irwrite_rdy", 32'(bus.IRWrite), 32'd1);
    checkOutput("rst_pcwrite_rdy", 32'(bus.PCWrite), 32'd1);
    applyStimulus(6'b0, 1'b0);
    checkOutput("rst_irwrite_nrdy", 32'(bus.IRWrite), 32'd0);
    checkOutput("rst_pcwrite_nrdy", 32'(bus.PCWrite), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // lw: 0,1,2,3,4,0
    applyStimulus(6'b100011, 1'b1);
    checkOutput("lw_s0", 32'(bus.state), 32'd0);
    tick;
    checkOutput("lw_s1", 32'(bus.state), 32'd1);
    checkOutput("lw_dec_alusrcb", 32'(bus.ALUSrcB), 32'd3);
    tick;
    checkOutput("lw_s2", 32'(bus.state), 32'd2);
    checkOutput("lw_addr_alusrcb", 32'(bus.ALUSrcB), 32'd2);
    checkOutput("lw_addr_alusrca", 32'(bus.ALUSrcA), 32'd1);
    checkOutput("lw_addr_regwrite", 32'(bus.RegWrite), 32'd0);
    tick;
    checkOutput("lw_s3", 32'(bus.state), 32'd3);
    checkOutput("lw_rd_iord", 32'(bus.IorD), 32'd1);
    checkOutput("lw_rd_memread", 32'(bus.MemRead), 32'd1);
    checkOutput("lw_rd_regwrite", 32'(bus.RegWrite), 32'd0);
    tick;
    checkOutput("lw_s4", 32'(bus.state), 32'd4);
    checkOutput("lw_wb_regwrite", 32'(bus.RegWrite), 32'd1);
    checkOutput("lw_wb_memtoreg", 32'(bus.MemToReg), 32'd1);
    checkOutput("lw_wb_regdst", 32'(bus.RegDst), 32'd0);
    tick;
    checkOutput("lw_back_fetch", 32'(bus.state), 32'd0);
    checkOutput("lw_instret", bus.instret, 32'd1);
    checkOutput("lw_fetch_memtoreg", 32'(bus.MemToReg), 32'd0);

    // FETCH stall does not advance or retire
    applyStimulus(6'b101011, 1'b0);
    checkOutput("fstall_irwrite", 32'(bus.IRWrite), 32'd0);
    tick;
    checkOutput("fstall_state", 32'(bus.state), 32'd0);
    checkOutput("fstall_instret", bus.instret, 32'd1);

    // sw with three stall cycles in MEM_WRITE
    applyStimulus(6'b101011, 1'b1);
    checkOutput("sw_fetch_irwrite", 32'(bus.IRWrite), 32'd1);
    tick;
    checkOutput("sw_s1", 32'(bus.state), 32'd1);
    tick;
    checkOutput("sw_s2", 32'(bus.state), 32'd2);
    tick;
    applyStimulus(6'b101011, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("sw_stall_state", 32'(bus.state), 32'd5);
      checkOutput("sw_stall_memwrite", 32'(bus.MemWrite), 32'd1);
      checkOutput("sw_stall_iord", 32'(bus.IorD), 32'd1);
      checkOutput("sw_stall_regwrite", 32'(bus.RegWrite), 32'd0);
      tick;
    end
    applyStimulus(6'b101011, 1'b1);
    checkOutput("sw_last_state", 32'(bus.state), 32'd5);
    checkOutput("sw_last_memwrite", 32'(bus.MemWrite), 32'd1);
    checkOutput("sw_last_memread", 32'(bus.MemRead), 32'd0);
    tick;
    checkOutput("sw_back_fetch", 32'(bus.state), 32'd0);
    checkOutput("sw_instret", bus.instret, 32'd2);

    // andi: zero-extended AND
    applyStimulus(6'b001100, 1'b1);
    tick;
    tick;
    checkOutput("andi_s10", 32'(bus.state), 32'd10);
    checkOutput("andi_aluop", 32'(bus.ALUOp), 32'd4);
    checkOutput("andi_extop", 32'(bus.ExtOp), 32'd1);
    checkOutput("andi_alusrcb", 32'(bus.ALUSrcB), 32'd2);
    tick;
    checkOutput("andi_s11", 32'(bus.state), 32'd11);
    checkOutput("andi_wb_regwrite", 32'(bus.RegWrite), 32'd1);
    checkOutput("andi_wb_extop", 32'(bus.ExtOp), 32'd1);
    checkOutput("andi_wb_regdst", 32'(bus.RegDst), 32'd0);
    tick;
    checkOutput("andi_back_fetch", 32'(bus.state), 32'd0);
    checkOutput("andi_instret", bus.instret, 32'd3);

    // slti: sign-extended set-less-than
    applyStimulus(6'b001010, 1'b1);
    tick;
    tick;
    checkOutput("slti_s10", 32'(bus.state), 32'd10);
    checkOutput("slti_aluop", 32'(bus.ALUOp), 32'd3);
    checkOutput("slti_extop", 32'(bus.ExtOp), 32'd0);
    tick;
    checkOutput("slti_s11", 32'(bus.state), 32'd11);
    tick;
    checkOutput("slti_instret", bus.instret, 32'd4);

    // ori for the OR code
    applyStimulus(6'b001101, 1'b1);
    tick;
    tick;
    checkOutput("ori_aluop", 32'(bus.ALUOp), 32'd5);
    checkOutput("ori_extop", 32'(bus.ExtOp), 32'd1);
    tick;
    tick;
    checkOutput("ori_instret", bus.instret, 32'd5);

    // R-type
    applyStimulus(6'b000000, 1'b1);
    tick;
    tick;
    checkOutput("r_s6", 32'(bus.state), 32'd6);
    checkOutput("r_aluop", 32'(bus.ALUOp), 32'd2);
    checkOutput("r_alusrcb", 32'(bus.ALUSrcB), 32'd0);
    tick;
    checkOutput("r_s7", 32'(bus.state), 32'd7);
    checkOutput("r_regdst", 32'(bus.RegDst), 32'd1);
    checkOutput("r_regwrite", 32'(bus.RegWrite), 32'd1);
    tick;
    checkOutput("r_instret", bus.instret, 32'd6);

    // beq then j, mem_ready ignored outside memory states
    applyStimulus(6'b000100, 1'b1);
    tick;
    applyStimulus(6'b000100, 1'b0);
    tick;
    checkOutput("beq_s8", 32'(bus.state), 32'd8);
    checkOutput("beq_pcwritecond", 32'(bus.PCWriteCond), 32'd1);
    checkOutput("beq_pcsource", 32'(bus.PCSource), 32'd1);
    checkOutput("beq_aluop", 32'(bus.ALUOp), 32'd1);
    checkOutput("beq_pcwrite", 32'(bus.PCWrite), 32'd0);
    tick;
    checkOutput("beq_back_fetch", 32'(bus.state), 32'd0);
    applyStimulus(6'b000010, 1'b1);
    tick;
    tick;
    checkOutput("j_s9", 32'(bus.state), 32'd9);
    checkOutput("j_pcwrite", 32'(bus.PCWrite), 32'd1);
    checkOutput("j_pcsource", 32'(bus.PCSource), 32'd2);
    tick;
    checkOutput("j_instret", bus.instret, 32'd8);

    // Reset asserted while stalled in MEM_READ
    applyStimulus(6'b100011, 1'b1);
    tick;
    tick;
    tick;
    applyStimulus(6'b100011, 1'b0);
    checkOutput("rdstall_s3", 32'(bus.state), 32'd3);
    tick;
    checkOutput("rdstall_hold", 32'(bus.state), 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_state", 32'(bus.state), 32'd0);
    checkOutput("midrst_instret", bus.instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // instret wrap from all-ones on an R-type
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    checkOutput("wrap_preload", bus.instret, 32'hFFFF_FFFF);
    applyStimulus(6'b000000, 1'b1);
    tick;
    tick;
    tick;
    tick;
    checkOutput("wrap_state", 32'(bus.state), 32'd0);
    checkOutput("wrap_instret", bus.instret, 32'd0);

    // Undefined opcode
    applyStimulus(6'b111111, 1'b1);
    tick;
    tick;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      checkOutput("trap_state", 32'(bus.state), 32'd12);
      checkOutput("trap_illegal", 32'(bus.illegal), 32'd1);
      checkOutput("trap_memread", 32'(bus.MemRead), 32'd0);
      checkOutput("trap_pcwrite", 32'(bus.PCWrite), 32'd0);
      checkOutput("trap_instret", bus.instret, 32'd0);
      tick;
    end
`else
    checkOutput("nop_state", 32'(bus.state), 32'd0);
    checkOutput("nop_illegal", 32'(bus.illegal), 32'd0);
    checkOutput("nop_instret", bus.instret, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
